seg7_scanner: RTL and testbench

SEG7_SCANNER -- requirements
Module: seg7_scanner

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scanner.sv | 72 +++++++
 tb/tb_seg7_scanner.sv | 129 ++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and hex-to-segment table for the 7-segment scanner
//   DIGITS_DEF : default number of multiplexed digits
//   SEG_BLANK  : all segments off (active-low)
//   SEG_ZERO   : pattern for hex 0, dp off
//   HEX_SEG    : active-low {dp,g,f,e,d,c,b,a} pattern per nibble, dp bit off
package seg7_pkg;
   localparam int DIGITS_DEF = 8;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_ZERO = 8'hC0;
   localparam logic [15:0][7:0] HEX_SEG = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble to active-low 7-segment lookup
//   nib : hex digit in
//   seg : {g,f,e,d,c,b,a}, active-low
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   assign seg = HEX_SEG[nib][6:0];
endmodule

// File: rtl/seg7_scanner.sv
// seg7_scanner: multiplexed hex display driver stepping one digit per scan_clk rising edge
//   I_CLK    : system clock
//   rst      : synchronous active-high reset
//   scan_clk : divided scan clock, sampled as asynchronous data
//   data     : 4 bits per digit, digit i = data[4i+3:4i]
//   blank    : per-digit blank, 1 = all segments off
//   dp       : per-digit decimal point, 1 = lit
//   an       : registered one-hot active-low digit select
//   seg      : registered active-low {dp,g,f,e,d,c,b,a}
module seg7_scanner
   import seg7_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                I_CLK,
   input  logic                rst,
   input  logic                scan_clk,
   input  logic [4*DIGITS-1:0] data,
   input  logic [DIGITS-1:0]   blank,
   input  logic [DIGITS-1:0]   dp,
   output logic [DIGITS-1:0]   an,
   output logic [7:0]          seg
);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   logic s1, s2, s3, tick, wrap;
   logic [IW-1:0] idx, idx_next;
   logic [4*DIGITS-1:0] data_sh, cur_data;
   logic [DIGITS-1:0] blank_sh, dp_sh, cur_blank, cur_dp, an_next;
   logic [6:0] seg7;
   logic [7:0] seg_next;
   assign tick = s2 & ~s3;
   assign wrap = idx == IW'(DIGITS - 1);
   assign idx_next = wrap ? '0 : idx + 1'b1;
   // The wrap edge both captures the new frame and shows its digit 0, so it
   // must look at the live inputs rather than the not-yet-updated shadow.
   assign cur_data = wrap ? data : data_sh;
   assign cur_blank = wrap ? blank : blank_sh;
   assign cur_dp = wrap ? dp : dp_sh;
   assign an_next = ~(DIGITS'(1) << idx_next);
   assign seg_next = cur_blank[idx_next] ? SEG_BLANK : {~cur_dp[idx_next], seg7};
   seg7_decode u_dec (
      .nib(cur_data[{idx_next, 2'b00} +: 4]),
      .seg(seg7)
   );
   always_ff @(posedge I_CLK) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
         idx <= '0;
         data_sh <= '0;
         blank_sh <= '0;
         dp_sh <= '0;
         an <= ~DIGITS'(1);
         seg <= SEG_ZERO;
      end else begin
         s1 <= scan_clk;
         s2 <= s1;
         s3 <= s2;
         if (tick) begin
            idx <= idx_next;
            an <= an_next;
            seg <= seg_next;
            if (wrap) begin
               data_sh <= data;
               blank_sh <= blank;
               dp_sh <= dp;
            end
         end
      end
   end
endmodule

// File: tb/tb_seg7_scanner.sv
// tb_seg7_scanner: randomized self-checking bench against a frame-level display model
module tb_seg7_scanner;
   localparam int N = 8;
   logic I_CLK = 1'b0, rst = 1'b1, scan_clk = 1'b0;
   logic [4*N-1:0] data = '0;
   logic [N-1:0] blank = '0, dp = '0, an;
   logic [7:0] seg;
   int checks = 0, errors = 0;
   int pos = 0;
   logic [4*N-1:0] f_data = '0;
   logic [N-1:0] f_blank = '0, f_dp = '0;
   logic [7:0] hex [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   seg7_scanner #(.DIGITS(N)) dut (
      .I_CLK(I_CLK),
      .rst(rst),
      .scan_clk(scan_clk),
      .data(data),
      .blank(blank),
      .dp(dp),
      .an(an),
      .seg(seg)
   );
   always #5 I_CLK = ~I_CLK;
   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1);
   end
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
      end
   endtask
   function automatic logic [7:0] exp_seg();
      logic [3:0] n;
      n = f_data[4*pos +: 4];
      if (f_blank[pos]) return 8'hFF;
      return hex[n] & (f_dp[pos] ? 8'h7F : 8'hFF);
   endfunction
   task automatic check_out(string tag);
      check({tag, "_an"}, 32'(an), 32'({N{1'b1}} ^ (N'(1) << pos)));
      check({tag, "_seg"}, 32'(seg), 32'(exp_seg()));
   endtask
   task automatic model_step();
      if (pos == N - 1) begin
         pos = 0;
         f_data = data;
         f_blank = blank;
         f_dp = dp;
      end else pos++;
   endtask
   task automatic model_reset();
      pos = 0;
      f_data = '0;
      f_blank = '0;
      f_dp = '0;
   endtask
   // scan_clk rises at a negedge, so the next posedge is the first sampling edge
   // and the display must change exactly at the third posedge after it.
   task automatic pulse(int hi, int lo);
      scan_clk = 1'b1;
      for (int i = 1; i <= hi + lo; i++) begin
         @(posedge I_CLK);
         if (i == 3) model_step();
         @(negedge I_CLK);
         check_out("scan");
         if (i == hi) scan_clk = 1'b0;
      end
   endtask
   task automatic run_to(int p);
      while (pos != p) pulse(4, 4);
   endtask
   initial begin
      repeat (2) @(negedge I_CLK);
      check_out("rst");
      rst = 1'b0;
      repeat (20) begin
         @(negedge I_CLK);
         check_out("idle");
      end
      data = 32'h76543210;
      repeat (16) pulse(4, 4);
      data = 32'hDEADBEEF;
      run_to(3);
      data = 32'hFEDCBA98;
      run_to(0);
      check("wrap_d0", 32'(seg), 32'h80);
      pulse(4, 4);
      check("wrap_d1", 32'(seg), 32'h90);
      blank = 8'h02;
      dp = 8'h01;
      data = '0;
      run_to(0);
      check("dp_d0", 32'(seg), 32'h40);
      pulse(4, 4);
      check("blank_d1_seg", 32'(seg), 32'hFF);
      check("blank_d1_an", 32'(an), 32'hFD);
      run_to(5);
      scan_clk = 1'b1;
      rst = 1'b1;
      @(posedge I_CLK);
      model_reset();
      @(negedge I_CLK);
      check_out("rst_mid");
      rst = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge I_CLK);
         if (i == 3) model_step();
         @(negedge I_CLK);
         check_out("rel");
         if (i == 4) scan_clk = 1'b0;
      end
      check("rel_an", 32'(an), 32'hFD);
      pulse(50, 4);
      repeat (80) begin
         if ($urandom_range(0, 2) == 0) begin
            data = $urandom;
            blank = N'($urandom_range(0, 255));
            dp = N'($urandom_range(0, 255));
         end
         pulse($urandom_range(2, 6), $urandom_range(2, 6));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
